// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline stall/flush sequencer: FSM states, control-word
// layout and the priority encoding that picks which control word drives the pipe.
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    HALT     = 2'd2
  } ctrl_state_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // Highest value wins.
  typedef enum logic [2:0] {
    PRIO_NONE   = 3'd0,
    PRIO_BRANCH = 3'd1,
    PRIO_STALL  = 3'd2,
    PRIO_FREEZE = 3'd3,
    PRIO_HALT   = 3'd4,
    PRIO_RESET  = 3'd5
  } ctrl_prio_t;

  typedef struct packed {
    logic pc_en;
    logic ifid_en;
    logic idex_en;
    logic exmem_en;
    logic ifid_flush;
    logic idex_flush;
    logic memwb_flush;
  } ctrl_t;

  function automatic ctrl_prio_t ctrl_prio(input logic rst, input logic halt,
                                           input logic freeze, input logic stall,
                                           input logic branch);
    if (rst)         return PRIO_RESET;
    else if (halt)   return PRIO_HALT;
    else if (freeze) return PRIO_FREEZE;
    else if (stall)  return PRIO_STALL;
    else if (branch) return PRIO_BRANCH;
    else             return PRIO_NONE;
  endfunction

  function automatic ctrl_t ctrl_decode(input ctrl_prio_t p);
    case (p)
      PRIO_RESET:  return 7'b0000_111;
      PRIO_HALT:   return 7'b0000_001;
      PRIO_FREEZE: return 7'b0000_001;
      // Bubble into ID/EX while PC and IF/ID hold; older instructions keep moving.
      PRIO_STALL:  return 7'b0011_010;
      PRIO_BRANCH: return 7'b1111_100;
      default:     return 7'b1111_000;
    endcase
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW-hazard check of the ID instruction against EX and MEM producers.
// PIPE_FORWARDING_EN defined: only load-use stalls; undefined: every EX/MEM match stalls.
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] i_id_rs,
  input  logic [4:0] i_id_rt,
  input  logic       i_id_uses_rt,
  input  logic       i_ex_reg_write,
  input  logic       i_ex_mem_read,
  input  logic [4:0] i_ex_rd,
  input  logic       i_mem_reg_write,
  input  logic [4:0] i_mem_rd,
  output logic       o_raw_stall
);

  logic w_ex_match;
  logic w_mem_match;
  logic w_load_use;

  assign w_ex_match  = (i_ex_rd != REG_ZERO) &&
                       ((i_ex_rd == i_id_rs) || (i_id_uses_rt && (i_ex_rd == i_id_rt)));
  assign w_mem_match = (i_mem_rd != REG_ZERO) &&
                       ((i_mem_rd == i_id_rs) || (i_id_uses_rt && (i_mem_rd == i_id_rt)));
  assign w_load_use  = i_ex_mem_read && w_ex_match;

`ifdef PIPE_FORWARDING_EN
  logic w_unused_nofwd;
  assign w_unused_nofwd = ^{i_ex_reg_write, i_mem_reg_write, w_mem_match};
  assign o_raw_stall    = w_load_use;
`else
  // WB producers are safe: the register file writes in the first half-cycle.
  assign o_raw_stall = w_load_use ||
                       (i_ex_reg_write && w_ex_match) ||
                       (i_mem_reg_write && w_mem_match);
`endif

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipe: memory freeze, load-use/RAW stall, branch flush.
// Optional forwarding-aware hazard rule selected by macro PIPE_FORWARDING_EN.
module pipeline_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_reg_write,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             mem_reg_write,
  input  logic [4:0]       mem_rd,
  input  logic             mem_access,
  input  logic             dmem_ready,
  input  logic             branch_taken,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             halted,
  output logic [CNT_W-1:0] stall_count
);

  localparam int WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  ctrl_state_t       r_state;
  ctrl_state_t       w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              r_halted;
  logic [CNT_W-1:0]  r_stall_count;
  logic              w_freeze;
  logic              w_raw_stall;
  ctrl_t             w_ctrl;

  hazard_detect u_hazard_detect (
    .i_id_rs         (id_rs),
    .i_id_rt         (id_rt),
    .i_id_uses_rt    (id_uses_rt),
    .i_ex_reg_write  (ex_reg_write),
    .i_ex_mem_read   (ex_mem_read),
    .i_ex_rd         (ex_rd),
    .i_mem_reg_write (mem_reg_write),
    .i_mem_rd        (mem_rd),
    .o_raw_stall     (w_raw_stall)
  );

  assign w_freeze = mem_access && !dmem_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= RUN;
      r_wait_cnt    <= '0;
      r_halted      <= 1'b0;
      r_stall_count <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_halted   <= r_halted || (w_state_nxt == HALT);
      if ((r_state != HALT) && !w_ctrl.pc_en && (r_stall_count != {CNT_W{1'b1}}))
        r_stall_count <= r_stall_count + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      RUN: begin
        if (w_freeze) w_state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (dmem_ready)                    w_state_nxt = RUN;
        else if (r_wait_cnt == WAIT_LAST)  w_state_nxt = HALT;
        else                               w_wait_cnt_nxt = r_wait_cnt + 1'b1;
      end
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = RUN;
    endcase
    if (w_state_nxt == RUN) w_wait_cnt_nxt = '0;

    w_ctrl = ctrl_decode(ctrl_prio(reset, r_state == HALT, w_freeze,
                                   w_raw_stall, branch_taken));
  end

  assign pc_en       = w_ctrl.pc_en;
  assign ifid_en     = w_ctrl.ifid_en;
  assign idex_en     = w_ctrl.idex_en;
  assign exmem_en    = w_ctrl.exmem_en;
  assign ifid_flush  = w_ctrl.ifid_flush;
  assign idex_flush  = w_ctrl.idex_flush;
  assign memwb_flush = w_ctrl.memwb_flush;
  assign halted      = r_halted;
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: vector table plus freeze, no-forwarding and timeout sequences.
module tb_pipeline_hazard_ctrl;

  localparam logic [6:0] C_RUN = 7'b1111_000;
  localparam logic [6:0] C_BR  = 7'b1111_100;
  localparam logic [6:0] C_LU  = 7'b0011_010;
  localparam logic [6:0] C_FRZ = 7'b0000_001;
  localparam logic [6:0] C_RST = 7'b0000_111;
  localparam logic [6:0] M_ALL = 7'b1111_111;
  localparam logic [6:0] M_LU  = 7'b1101_111;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  id_rs, id_rt, ex_rd, mem_rd;
  logic        id_uses_rt, ex_reg_write, ex_mem_read, mem_reg_write;
  logic        mem_access, dmem_ready, branch_taken;
  logic        pc_en, ifid_en, idex_en, exmem_en;
  logic        ifid_flush, idex_flush, memwb_flush, halted;
  logic [15:0] stall_count;
  logic [6:0]  act;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic [4:0] rs, rt;
    logic       uses_rt, mr;
    logic [4:0] rd;
    logic       br;
    logic [6:0] exp, care;
    int         exp_cnt;
  } vec_t;

  vec_t vecs [9];

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(4), .CNT_W(16)) dut (
    .clk(clk), .reset(reset),
    .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
    .mem_reg_write(mem_reg_write), .mem_rd(mem_rd),
    .mem_access(mem_access), .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .halted(halted), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  assign act = {pc_en, ifid_en, idex_en, exmem_en, ifid_flush, idex_flush, memwb_flush};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle();
    id_rs = 5'd1; id_rt = 5'd2; id_uses_rt = 1'b0;
    ex_reg_write = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0;
    mem_reg_write = 1'b0; mem_rd = 5'd0;
    mem_access = 1'b0; dmem_ready = 1'b1; branch_taken = 1'b0;
  endtask

  task automatic check_ctrl(input string name, input logic [6:0] exp, input logic [6:0] care);
    checks++;
    if ((act & care) !== (exp & care)) begin
      errors++;
      $display("FAIL %s: ctrl=%b required=%b (care %b)", name, act, exp, care);
    end
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d required %0d", name, got, exp);
    end
  endtask

  initial begin
    vecs[0] = '{"idle",        5'd1,  5'd2,  1'b0, 1'b0, 5'd0,  1'b0, C_RUN, M_ALL, 0};
    vecs[1] = '{"lu_rs",       5'd8,  5'd2,  1'b0, 1'b1, 5'd8,  1'b0, C_LU,  M_LU,  1};
    vecs[2] = '{"lu_rt",       5'd3,  5'd9,  1'b1, 1'b1, 5'd9,  1'b0, C_LU,  M_LU,  2};
    vecs[3] = '{"rt_unused",   5'd3,  5'd9,  1'b0, 1'b1, 5'd9,  1'b0, C_RUN, M_ALL, 2};
    vecs[4] = '{"reg_zero",    5'd0,  5'd0,  1'b1, 1'b1, 5'd0,  1'b0, C_RUN, M_ALL, 2};
    vecs[5] = '{"lu_rs_rt",    5'd10, 5'd10, 1'b1, 1'b1, 5'd10, 1'b0, C_LU,  M_LU,  3};
    vecs[6] = '{"branch",      5'd4,  5'd5,  1'b1, 1'b0, 5'd4,  1'b1, C_BR,  M_ALL, 3};
    vecs[7] = '{"branch_lu",   5'd7,  5'd2,  1'b0, 1'b1, 5'd7,  1'b1, C_LU,  M_LU,  4};
    vecs[8] = '{"lu_mismatch", 5'd6,  5'd11, 1'b1, 1'b1, 5'd12, 1'b0, C_RUN, M_ALL, 4};

    set_idle();
    reset = 1'b1;
    step();
    @(negedge clk);
    check_ctrl("reset_ctrl", C_RST, M_ALL);
    step();
    reset = 1'b0;
    check_val("reset_halted", 32'(halted), 32'd0);
    check_val("reset_stall_count", 32'(stall_count), 32'd0);

    for (int i = 0; i < 9; i++) begin
      id_rs = vecs[i].rs; id_rt = vecs[i].rt; id_uses_rt = vecs[i].uses_rt;
      ex_mem_read = vecs[i].mr; ex_rd = vecs[i].rd; branch_taken = vecs[i].br;
      @(negedge clk);
      check_ctrl(vecs[i].name, vecs[i].exp, vecs[i].care);
      step();
      check_val({vecs[i].name, "_cnt"}, 32'(stall_count), 32'(vecs[i].exp_cnt));
    end

    // Memory freeze overrides a concurrent load-use hazard and branch.
    set_idle();
    mem_access = 1'b1; dmem_ready = 1'b0;
    ex_mem_read = 1'b1; ex_rd = 5'd8; id_rs = 5'd8; branch_taken = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_ctrl("mem_freeze", C_FRZ, M_ALL);
      step();
    end
    set_idle();
    mem_access = 1'b1; dmem_ready = 1'b1;
    @(negedge clk);
    check_ctrl("mem_ready", C_RUN, M_ALL);
    step();
    check_val("mem_wait_cnt", 32'(stall_count), 32'd7);
    mem_access = 1'b0;
    @(negedge clk);
    check_ctrl("after_mem_run", C_RUN, M_ALL);
    step();

    // EX producer then the same producer in MEM.
    set_idle();
    ex_reg_write = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
    @(negedge clk);
`ifdef PIPE_FORWARDING_EN
    check_ctrl("raw_ex", C_RUN, M_ALL);
`else
    check_ctrl("raw_ex", C_LU, M_LU);
`endif
    step();
    ex_reg_write = 1'b0; ex_rd = 5'd0; mem_reg_write = 1'b1; mem_rd = 5'd5;
    @(negedge clk);
`ifdef PIPE_FORWARDING_EN
    check_ctrl("raw_mem", C_RUN, M_ALL);
`else
    check_ctrl("raw_mem", C_LU, M_LU);
`endif
    step();
    set_idle();
    @(negedge clk);
    check_ctrl("raw_clear", C_RUN, M_ALL);
    step();
`ifdef PIPE_FORWARDING_EN
    check_val("raw_cnt", 32'(stall_count), 32'd7);
`else
    check_val("raw_cnt", 32'(stall_count), 32'd9);
`endif

    // Timeout: one RUN cycle plus MEM_TIMEOUT cycles in MEM_WAIT, then sticky halt.
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_val("to_reset_cnt", 32'(stall_count), 32'd0);
    mem_access = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_val("to_not_halted", 32'(halted), 32'd0);
      step();
    end
    check_val("to_halted", 32'(halted), 32'd1);
    set_idle();
    step();
    step();
    @(negedge clk);
    check_val("to_halt_sticky", 32'(halted), 32'd1);
    check_ctrl("to_halt_ctrl", C_FRZ, M_ALL);
    check_val("to_halt_cnt_hold", 32'(stall_count), 32'd5);
    reset = 1'b1;
    #1;
    check_ctrl("to_reset_ctrl", C_RST, M_ALL);
    step();
    reset = 1'b0;
    check_val("to_reset_halted", 32'(halted), 32'd0);
    check_val("to_reset_cnt2", 32'(stall_count), 32'd0);
    @(negedge clk);
    check_ctrl("to_after_reset", C_RUN, M_ALL);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
